// File: rtl/hex_scan_display_pkg.sv
// Shared constants, slot type and glyph lookup for the scanned hex display.
// Segment order is {a,b,c,d,e,f,g} with a at bit 6, active-high.
package hex_display_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] GLYPH_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] GLYPH_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] GLYPH_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] GLYPH_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] GLYPH_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b0000001;

    typedef struct packed {
        logic       full;
        logic       is_dash;
        logic [3:0] value;
    } slot_t;

    function automatic logic [SEG_W-1:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

    function automatic logic [SEG_W-1:0] slot_glyph(input slot_t s);
        if (!s.full)
            return GLYPH_BLANK;
        else if (s.is_dash)
            return GLYPH_DASH;
        else
            return glyph(s.value);
    endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// Code stream in, multiplexed segment bank out. Parameters must match the
// display instance that the slave modport is bound to.
interface hex_scan_display_if #(
    parameter int CODE_W = 8,
    parameter int DIGITS = 4
);
    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              clear;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_sel;
    logic [3:0]        last_value;
    logic              code_err;

    modport master (
        output code_valid, code, clear,
        input  seg, dig_sel, last_value, code_err
    );

    modport slave (
        input  code_valid, code, clear,
        output seg, dig_sel, last_value, code_err
    );
endinterface

// File: rtl/hex_scan_display_decoder.sv
// Pulse-pair code decoder: a valid word is "10" repeated k+1 times from the
// MSB followed by zeros; the digit value is k.
module hex_code_decoder #(
    parameter int CODE_W = 8
) (
    input  logic [CODE_W-1:0] code_i,
    output logic              valid_o,
    output logic [3:0]        value_o
);

    function automatic logic [CODE_W-1:0] pattern(input int k);
        logic [CODE_W-1:0] p;
        p = '0;
        for (int j = 0; j < CODE_W/2; j++) begin
            if (j <= k)
                p[CODE_W-1-2*j] = 1'b1;
        end
        return p;
    endfunction

    always_comb begin
        valid_o = 1'b0;
        value_o = '0;
        for (int k = 0; k < CODE_W/2; k++) begin
            if (code_i == pattern(k)) begin
                valid_o = 1'b1;
                value_o = 4'(k);
            end
        end
    end

endmodule

// File: rtl/hex_scan_display.sv
// Scrolling DIGITS-deep history of decoded codes on a multiplexed 7-seg bank.
// Define HEX_SCAN_DISPLAY_ERR_GLYPH_EN to push a dash for invalid codes.
module hex_scan_display
    import hex_display_pkg::*;
#(
    parameter int CODE_W   = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    hex_scan_display_if.slave   bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    slot_t             slots_q [DIGITS];
    slot_t             slots_d [DIGITS];
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [3:0]        last_q, last_d;
    logic              err_q, err_d;

    logic              dec_valid;
    logic [3:0]        dec_value;
    logic              push;
    slot_t             new_slot;

    hex_code_decoder #(.CODE_W(CODE_W)) u_dec (
        .code_i  (bus.code),
        .valid_o (dec_valid),
        .value_o (dec_value)
    );

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // clear takes priority over a same-cycle code, which is then dropped silently
    always_comb begin
        push     = 1'b0;
        new_slot = '0;
        last_d   = last_q;
        err_d    = 1'b0;
        if (bus.code_valid && !bus.clear) begin
            if (dec_valid) begin
                push     = 1'b1;
                new_slot = '{full: 1'b1, is_dash: 1'b0, value: dec_value};
                last_d   = dec_value;
            end else begin
                err_d = 1'b1;
`ifdef HEX_SCAN_DISPLAY_ERR_GLYPH_EN
                push     = 1'b1;
                new_slot = '{full: 1'b1, is_dash: 1'b1, value: 4'h0};
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            slots_d[i] = slots_q[i];
        if (bus.clear) begin
            for (int i = 0; i < DIGITS; i++)
                slots_d[i] = '0;
        end else if (push) begin
            slots_d[0] = new_slot;
            for (int i = 1; i < DIGITS; i++)
                slots_d[i] = slots_q[i-1];
        end
    end

    // Both outputs derive from the same idx_q so the pair can never disagree
    always_comb begin
        dig_sel_d = DIGITS'(1) << idx_q;
        seg_d     = slot_glyph(slots_q[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            idx_q     <= '0;
            for (int i = 0; i < DIGITS; i++)
                slots_q[i] <= '0;
            seg_q     <= GLYPH_BLANK;
            dig_sel_q <= DIGITS'(1);
            last_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            for (int i = 0; i < DIGITS; i++)
                slots_q[i] <= slots_d[i];
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_sel_q;
    assign bus.last_value = last_q;
    assign bus.code_err   = err_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench: directed walk-through plus random code traffic against
// a history/timing model of the display (CODE_W=8, DIGITS=4, SCAN_DIV=4).
module tb_hex_scan_display;

    localparam int CW = 8;
    localparam int ND = 4;
    localparam int SD = 4;

    logic clk;
    logic rst_n;

    hex_scan_display_if #(.CODE_W(CW), .DIGITS(ND)) dif ();

    hex_scan_display #(.CODE_W(CW), .DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] gl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // hist[i]: -1 empty, 0..15 digit, 16 dash
    int hist [ND];
    int n_edges;
    int exp_last;
    int exp_err;
    int exp_seg;
    int exp_dig;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [CW-1:0] c);
        logic [CW-1:0] p;
        p = '0;
        for (int k = 0; k < CW/2; k++) begin
            p = p | (CW'(1) << (CW - 1 - 2*k));
            if (c == p) return k;
        end
        return -1;
    endfunction

    function automatic logic [CW-1:0] rand_code();
        logic [CW-1:0] p;
        int sel;
        sel = int'($urandom_range(0, 9));
        p = '0;
        if (sel <= 5) begin
            for (int j = 0; j <= int'($urandom_range(0, CW/2-1)); j++)
                p = p | (CW'(1) << (CW - 1 - 2*j));
        end else if (sel == 6) begin
            p = '0;
        end else if (sel == 7) begin
            p = CW'($urandom);
        end else if (sel == 8) begin
            p = CW'($urandom) & 8'h7F;
        end else begin
            p = 8'hA0 | CW'(1 << $urandom_range(0, 4));
        end
        return p;
    endfunction

    function automatic int seg_of(input int h);
        if (h < 0) return 0;
        if (h == 16) return 1;
        return int'(gl[h]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) hist[i] = -1;
        n_edges  = 0;
        exp_last = 0;
        exp_err  = 0;
        exp_seg  = 0;
        exp_dig  = 1;
    endtask

    task automatic model_edge(input bit v, input logic [CW-1:0] c, input bit cl);
        int idx;
        int d;
        idx     = (n_edges / SD) % ND;
        exp_dig = 1 << idx;
        exp_seg = seg_of(hist[idx]);
        d       = decode(c);
        exp_err = (v && !cl && d < 0) ? 1 : 0;
        if (cl) begin
            for (int i = 0; i < ND; i++) hist[i] = -1;
        end else if (v) begin
            if (d >= 0) begin
                for (int i = ND-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0]  = d;
                exp_last = d;
            end else begin
`ifdef HEX_SCAN_DISPLAY_ERR_GLYPH_EN
                for (int i = ND-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = 16;
`endif
            end
        end
        n_edges++;
    endtask

    task automatic check_outputs(input string where);
        check({where, "/seg"},        32'(dif.seg),        32'(exp_seg));
        check({where, "/dig_sel"},    32'(dif.dig_sel),    32'(exp_dig));
        check({where, "/last_value"}, 32'(dif.last_value), 32'(exp_last));
        check({where, "/code_err"},   32'(dif.code_err),   32'(exp_err));
    endtask

    task automatic step(input bit v, input logic [CW-1:0] c, input bit cl);
        dif.code_valid = v;
        dif.code       = c;
        dif.clear      = cl;
        @(posedge clk);
        model_edge(v, c, cl);
        #1;
        check_outputs("run");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        dif.code_valid = 1'b0;
        dif.code       = '0;
        dif.clear      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        idle(32);

        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA8, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        idle(16);

        step(1'b1, 8'hA0, 1'b0);
        idle(16);

        step(1'b1, 8'hC0, 1'b0);
        idle(16);

        step(1'b1, 8'hA0, 1'b1);
        idle(16);
        step(1'b1, 8'hA8, 1'b0);
        idle(16);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, rand_code(), $urandom_range(0, 40) == 0);

        for (int i = 0; i < ND; i++) step(1'b1, 8'hAA, 1'b0);
        idle(1);
        while ((n_edges % (SD * ND)) != 2 * SD + 2) idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(24);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1) == 0, rand_code(), $urandom_range(0, 60) == 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
